// File: rtl/crc_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc_arb_pkg
//  Description : Shared types, constants and the round-robin pick function
//                used by the CRC packet arbiter and its tag FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package crc_arb_pkg;

    // Upper bound on requesters; rr_pick works on vectors of this width so it
    // can live in a package without being parameterised.
    localparam int MAX_SRC      = 16;
    localparam int MAX_SRC_BITS = 4;

    // Arbiter FSM encoding
    typedef logic [0:0] arb_state_t;
    localparam arb_state_t S_IDLE = 1'b0;
    localparam arb_state_t S_BUSY = 1'b1;

    typedef struct packed {
        logic                    found;
        logic [MAX_SRC_BITS-1:0] idx;
    } rr_pick_t;

    // First valid source starting at ptr, wrapping modulo num_src.
    // The loop walks from the farthest offset down to offset 0 so the
    // nearest valid source is the last (and therefore winning) assignment.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_SRC-1:0]      valid,
        input logic [MAX_SRC_BITS-1:0] ptr,
        input int                      num_src
    );
        rr_pick_t r;
        int       j;
        r = '0;
        for (int k = MAX_SRC - 1; k >= 0; k--) begin
            if (k < num_src) begin
                j = int'(ptr) + k;
                if (j >= num_src) j = j - num_src;
                if (valid[j[3:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[3:0];
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc_pkt_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : crc_tag_fifo
//  Description : Small synchronous FIFO holding the source ID of every packet
//                that has entered the CRC engine but whose result has not yet
//                come back. Registered occupancy count drives full/empty.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst       clock, async active-high reset
//                push_i, din_i  write a tag (ignored when full)
//                pop_i          drop head (ignored when empty)
//                dout_o         current head tag
//                full_o/empty_o occupancy flags from the registered count
// ============================================================================
module crc_tag_fifo
    import crc_arb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // Storage needs no reset: nothing is read until the count says so.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/crc_pkt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : crc_pkt_arbiter
//  Description : Shares one byte-enabled CRC engine between NUM_SRC packet
//                streams. Round-robin at packet granularity; the granted
//                source keeps the engine until its dlast flit. Source IDs ride
//                a tag FIFO so each engine result returns tagged.
//  Revision    : 1.0 - initial release
//  Ports       : s_din/s_byteEn/s_dlast/s_valid/s_ready  per-source flit streams
//                crc_din/crc_byteEn/crc_dlast/crc_flitEn to engine (1-cycle reg)
//                crc_out/crc_out_vld                     from engine
//                res_crc/res_src/res_vld                 tagged result
//                tag_err                                 sticky FIFO underflow
// ============================================================================
module crc_pkt_arbiter
    import crc_arb_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DWIDTH    = 512,
    parameter int CRC_WIDTH = 32,
    parameter int TAG_DEPTH = 16,
    localparam int SRC_BITS = $clog2(NUM_SRC),
    localparam int BEW      = DWIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*DWIDTH-1:0] s_din,
    input  logic [NUM_SRC*BEW-1:0]    s_byteEn,
    input  logic [NUM_SRC-1:0]        s_dlast,
    input  logic [NUM_SRC-1:0]        s_valid,
    output logic [NUM_SRC-1:0]        s_ready,
    output logic [DWIDTH-1:0]         crc_din,
    output logic [BEW-1:0]            crc_byteEn,
    output logic                      crc_dlast,
    output logic                      crc_flitEn,
    input  logic [CRC_WIDTH-1:0]      crc_out,
    input  logic                      crc_out_vld,
    output logic [CRC_WIDTH-1:0]      res_crc,
    output logic [SRC_BITS-1:0]       res_src,
    output logic                      res_vld,
    output logic                      tag_err
);

    arb_state_t          state_q, state_d;
    logic [SRC_BITS-1:0] owner_q, owner_d;
    logic [SRC_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_BITS-1:0] grant_src;
    rr_pick_t            pick;
    logic                accept, sel_last, push, pop;
    logic                tag_full, tag_empty;
    logic [SRC_BITS-1:0] tag_head;
    logic [DWIDTH-1:0]   sel_din;
    logic [BEW-1:0]      sel_be;

    always_comb pick = rr_pick(MAX_SRC'(s_valid), MAX_SRC_BITS'(rr_ptr_q), NUM_SRC);

    assign grant_src = (state_q == S_BUSY) ? owner_q : SRC_BITS'(pick.idx);
    assign sel_din   = s_din[grant_src*DWIDTH +: DWIDTH];
    assign sel_be    = s_byteEn[grant_src*BEW +: BEW];
    assign sel_last  = s_dlast[grant_src];

    // A new packet may only start when a tag slot is free; a pop in the same
    // cycle is deliberately not credited. A locked owner never pushes, so
    // its continuation flits are not gated by the FIFO level.
    always_comb begin
        s_ready = '0;
        if (!rst) begin
            if (state_q == S_BUSY)
                s_ready[owner_q] = 1'b1;
            else if (pick.found && !tag_full)
                s_ready[grant_src] = 1'b1;
        end
    end

    assign accept = |(s_valid & s_ready);
    assign push   = accept && (state_q == S_IDLE);
    assign pop    = crc_out_vld && !tag_empty;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if ((state_q == S_IDLE) && !sel_last) begin
                state_d = S_BUSY;
                owner_d = grant_src;
            end
            if (sel_last) begin
                state_d  = S_IDLE;
                rr_ptr_d = (grant_src == SRC_BITS'(NUM_SRC - 1)) ? '0 : grant_src + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            crc_flitEn <= 1'b0;
            crc_dlast  <= 1'b0;
            crc_byteEn <= '0;
            crc_din    <= '0;
            res_vld    <= 1'b0;
            res_crc    <= '0;
            res_src    <= '0;
            tag_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            crc_flitEn <= accept;
            if (accept) begin
                crc_din    <= sel_din;
                crc_byteEn <= sel_be;
                crc_dlast  <= sel_last;
            end else begin
                crc_dlast  <= 1'b0;
            end
            res_vld <= crc_out_vld;
            res_crc <= crc_out;
            res_src <= tag_head;
            if (crc_out_vld && tag_empty) tag_err <= 1'b1;
        end
    end

    crc_tag_fifo #(
        .WIDTH (SRC_BITS),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (grant_src),
        .pop_i   (pop),
        .dout_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_crc_pkt_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_crc_pkt_arbiter
//  Description : Directed bench for crc_pkt_arbiter. A behavioural CRC engine
//                (CRC-32 poly 04C11DB7, MSB-first bytes, init all-ones) sits
//                on the engine side and can hold its results back.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crc_pkt_arbiter;

    localparam int NS  = 4;
    localparam int DW  = 32;
    localparam int CW  = 32;
    localparam int TD  = 16;
    localparam int BEW = DW / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NS*DW-1:0]  s_din    = '0;
    logic [NS*BEW-1:0] s_byteEn = '0;
    logic [NS-1:0]     s_dlast  = '0;
    logic [NS-1:0]     s_valid  = '0;
    logic [NS-1:0]     s_ready;
    logic [DW-1:0]     crc_din;
    logic [BEW-1:0]    crc_byteEn;
    logic              crc_dlast, crc_flitEn;
    logic [CW-1:0]     crc_out     = '0;
    logic              crc_out_vld = 1'b0;
    logic [CW-1:0]     res_crc;
    logic [1:0]        res_src;
    logic              res_vld, tag_err;

    int checks = 0;
    int errors = 0;

    // engine model / observation state
    logic [31:0] eng_crc = 32'hFFFF_FFFF;
    logic [31:0] done_q[$];
    int          age_q[$];
    logic [1:0]  res_src_q[$];
    logic [31:0] res_crc_q[$];
    bit          release_en = 1'b1;
    bit          force_vld  = 1'b0;
    int          eng_delay  = 0;
    logic [3:0]  last_acc   = '0;

    crc_pkt_arbiter #(
        .NUM_SRC   (NS),
        .DWIDTH    (DW),
        .CRC_WIDTH (CW),
        .TAG_DEPTH (TD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_din       (s_din),
        .s_byteEn    (s_byteEn),
        .s_dlast     (s_dlast),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .crc_din     (crc_din),
        .crc_byteEn  (crc_byteEn),
        .crc_dlast   (crc_dlast),
        .crc_flitEn  (crc_flitEn),
        .crc_out     (crc_out),
        .crc_out_vld (crc_out_vld),
        .res_crc     (res_crc),
        .res_src     (res_src),
        .res_vld     (res_vld),
        .tag_err     (tag_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {b, 24'h0};
        for (int i = 0; i < 8; i++) r = r[31] ? ((r << 1) ^ 32'h04C1_1DB7) : (r << 1);
        return r;
    endfunction

    function automatic logic [31:0] crc_flit(input logic [31:0] c, input logic [31:0] d,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = c;
        for (int i = 3; i >= 0; i--) if (be[i]) r = crc_byte(r, d[i*8 +: 8]);
        return r;
    endfunction

    task automatic set_src(input int i, input logic [31:0] d, input logic [3:0] be,
                           input logic last, input logic v);
        s_din[i*DW +: DW]      = d;
        s_byteEn[i*BEW +: BEW] = be;
        s_dlast[i]             = last;
        s_valid[i]             = v;
    endtask

    // One clock: sample acceptance before the edge, then run the engine
    // model and result capture just after it.
    task automatic tick();
        #1;
        last_acc = s_valid & s_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            eng_crc = 32'hFFFF_FFFF;
            done_q.delete();
            age_q.delete();
        end else begin
            if (crc_flitEn) begin
                eng_crc = crc_flit(eng_crc, crc_din, crc_byteEn);
                if (crc_dlast) begin
                    done_q.push_back(eng_crc);
                    age_q.push_back(0);
                    eng_crc = 32'hFFFF_FFFF;
                end
            end
            if (res_vld) begin
                res_src_q.push_back(res_src);
                res_crc_q.push_back(res_crc);
            end
        end
        foreach (age_q[k]) age_q[k]++;
        crc_out_vld = 1'b0;
        if (force_vld) begin
            crc_out_vld = 1'b1;
            crc_out     = 32'hDEAD_BEEF;
            force_vld   = 1'b0;
        end else if (!rst && release_en && done_q.size() > 0 && age_q[0] > eng_delay) begin
            crc_out_vld = 1'b1;
            crc_out     = done_q.pop_front();
            void'(age_q.pop_front());
        end
    endtask

    task automatic drain(input int n, output bit ok);
        int g;
        g = 0;
        while (res_src_q.size() < n && g < 100) begin
            tick();
            g++;
        end
        ok = (res_src_q.size() >= n);
    endtask

    task automatic clear_res();
        res_src_q.delete();
        res_crc_q.delete();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        s_valid = '1;
        s_dlast = '1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (s_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 0000", s_ready);
        end
        checks++;
        if (crc_flitEn !== 1'b0 || crc_dlast !== 1'b0 || crc_byteEn !== 4'h0 || crc_din !== 32'h0) begin
            errors++;
            $display("FAIL reset_engine_if: got flitEn=%b dlast=%b be=%h din=%h expected all 0",
                     crc_flitEn, crc_dlast, crc_byteEn, crc_din);
        end
        checks++;
        if (res_vld !== 1'b0 || res_crc !== 32'h0 || res_src !== 2'd0 || tag_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: got vld=%b crc=%h src=%0d tag_err=%b expected all 0",
                     res_vld, res_crc, res_src, tag_err);
        end
        s_valid = '0;
        s_dlast = '0;
        rst     = 1'b0;
        tick();
    endtask

    task automatic test_single_src();
        logic [31:0] w [3];
        logic [31:0] exp_crc;
        bit ok;
        w[0] = 32'h1122_3344;
        w[1] = 32'h5566_7788;
        w[2] = 32'h99AA_BBCC;
        exp_crc = 32'hFFFF_FFFF;
        clear_res();
        for (int f = 0; f < 3; f++) begin
            set_src(0, w[f], 4'hF, (f == 2), 1'b1);
            tick();
            exp_crc = crc_flit(exp_crc, w[f], 4'hF);
            checks++;
            if (last_acc !== 4'b0001 || crc_flitEn !== 1'b1 || crc_din !== w[f] || crc_dlast !== (f == 2)) begin
                errors++;
                $display("FAIL single_flit%0d: got acc=%b flitEn=%b din=%h dlast=%b expected acc=0001 flitEn=1 din=%h dlast=%b",
                         f, last_acc, crc_flitEn, crc_din, crc_dlast, w[f], (f == 2));
            end
        end
        set_src(0, 32'h0, 4'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (crc_flitEn !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got flitEn=%b expected 0", crc_flitEn);
        end
        drain(1, ok);
        checks++;
        if (!ok || res_src_q[0] !== 2'd0 || res_crc_q[0] !== exp_crc) begin
            errors++;
            $display("FAIL single_result: got n=%0d src=%0d crc=%h expected src=0 crc=%h",
                     res_src_q.size(), ok ? res_src_q[0] : 2'd0, ok ? res_crc_q[0] : 32'h0, exp_crc);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        logic [3:0] e;
        clear_res();
        for (int i = 0; i < NS; i++) set_src(i, 32'hA000_0000 + i, 4'hF, 1'b1, 1'b1);
        // src0 finished last, so the pointer now sits at 1
        for (int k = 0; k < 8; k++) begin
            tick();
            e = 4'(1 << ((1 + k) % 4));
            checks++;
            if (last_acc !== e) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b expected %b", k, last_acc, e);
            end
        end
        s_valid = '0;
        drain(8, ok);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (!ok || res_src_q[k] !== 2'((1 + k) % 4)) begin
                errors++;
                $display("FAIL rr_res_src%0d: got %0d expected %0d", k,
                         ok ? res_src_q[k] : 2'd0, (1 + k) % 4);
            end
        end
    endtask

    task automatic test_lock();
        bit ok;
        logic [31:0] w [4];
        logic [31:0] exp1, exp2;
        w[0] = 32'h0101_0101;
        w[1] = 32'h0202_0202;
        w[2] = 32'h0303_0303;
        w[3] = 32'h0404_0404;
        exp1 = 32'hFFFF_FFFF;
        for (int f = 0; f < 4; f++) exp1 = crc_flit(exp1, w[f], 4'hF);
        exp2 = crc_flit(32'hFFFF_FFFF, 32'h2020_2020, 4'hF);
        clear_res();
        set_src(1, w[0], 4'hF, 1'b0, 1'b1);
        tick();
        set_src(1, w[1], 4'hF, 1'b0, 1'b1);
        set_src(2, 32'h2020_2020, 4'hF, 1'b1, 1'b1);
        tick();
        checks++;
        if (last_acc !== 4'b0010) begin
            errors++;
            $display("FAIL lock_flit1: got acc=%b expected 0010", last_acc);
        end
        set_src(1, w[1], 4'hF, 1'b0, 1'b0);
        for (int g = 0; g < 2; g++) begin
            tick();
            checks++;
            if (last_acc !== 4'b0000 || crc_flitEn !== 1'b0) begin
                errors++;
                $display("FAIL lock_gap%0d: got acc=%b flitEn=%b expected acc=0000 flitEn=0",
                         g, last_acc, crc_flitEn);
            end
        end
        set_src(1, w[2], 4'hF, 1'b0, 1'b1);
        tick();
        set_src(1, w[3], 4'hF, 1'b1, 1'b1);
        tick();
        checks++;
        if (last_acc !== 4'b0010 || crc_dlast !== 1'b1 || crc_din !== w[3]) begin
            errors++;
            $display("FAIL lock_last: got acc=%b dlast=%b din=%h expected acc=0010 dlast=1 din=%h",
                     last_acc, crc_dlast, crc_din, w[3]);
        end
        set_src(1, 32'h0, 4'h0, 1'b0, 1'b0);
        tick();
        checks++;
        if (last_acc !== 4'b0100) begin
            errors++;
            $display("FAIL lock_release: got acc=%b expected 0100", last_acc);
        end
        set_src(2, 32'h0, 4'h0, 1'b0, 1'b0);
        drain(2, ok);
        checks++;
        if (!ok || res_src_q[0] !== 2'd1 || res_crc_q[0] !== exp1 || res_src_q[1] !== 2'd2 || res_crc_q[1] !== exp2) begin
            errors++;
            $display("FAIL lock_results: got n=%0d expected src1 crc=%h then src2 crc=%h",
                     res_src_q.size(), exp1, exp2);
        end
    endtask

    task automatic test_tag_full();
        bit ok;
        int acc, guard;
        clear_res();
        release_en = 1'b0;
        acc = 0;
        for (int i = 0; i < NS; i++) set_src(i, 32'hB000_0000 + i, 4'hF, 1'b1, 1'b1);
        for (int t = 0; t < 18; t++) begin
            tick();
            if (last_acc !== 4'b0000) acc++;
        end
        checks++;
        if (acc != 16 || last_acc !== 4'b0000) begin
            errors++;
            $display("FAIL tag_full_stall: got accepted=%0d acc=%b expected accepted=16 acc=0000",
                     acc, last_acc);
        end
        release_en = 1'b1;
        guard = 0;
        while (acc < 20 && guard < 100) begin
            tick();
            if (last_acc !== 4'b0000) acc++;
            guard++;
        end
        s_valid = '0;
        checks++;
        if (acc != 20) begin
            errors++;
            $display("FAIL tag_full_resume: got accepted=%0d expected 20", acc);
        end
        drain(20, ok);
        // pointer was 3 after src2 finished the previous test
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (!ok || res_src_q[k] !== 2'((3 + k) % 4)) begin
                errors++;
                $display("FAIL tag_order%0d: got %0d expected %0d", k,
                         ok ? res_src_q[k] : 2'd0, (3 + k) % 4);
            end
        end
    endtask

    task automatic test_partial();
        bit ok;
        logic [31:0] exp_crc;
        exp_crc = crc_flit(crc_flit(32'hFFFF_FFFF, 32'hCAFE_F00D, 4'hF), 32'h1234_5678, 4'hE);
        clear_res();
        set_src(3, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1);
        tick();
        set_src(3, 32'h1234_5678, 4'hE, 1'b1, 1'b1);
        tick();
        checks++;
        if (crc_byteEn !== 4'hE || crc_dlast !== 1'b1 || last_acc !== 4'b1000) begin
            errors++;
            $display("FAIL partial_be: got be=%h dlast=%b acc=%b expected be=e dlast=1 acc=1000",
                     crc_byteEn, crc_dlast, last_acc);
        end
        set_src(3, 32'h0, 4'h0, 1'b0, 1'b0);
        drain(1, ok);
        checks++;
        if (!ok || res_src_q[0] !== 2'd3 || res_crc_q[0] !== exp_crc) begin
            errors++;
            $display("FAIL partial_crc: got src=%0d crc=%h expected src=3 crc=%h",
                     ok ? res_src_q[0] : 2'd0, ok ? res_crc_q[0] : 32'h0, exp_crc);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [31:0] exp_crc;
        exp_crc = crc_flit(32'hFFFF_FFFF, 32'h0BAD_CAFE, 4'hF);
        clear_res();
        set_src(3, 32'h3333_0001, 4'hF, 1'b0, 1'b1);
        tick();
        set_src(3, 32'h3333_0002, 4'hF, 1'b0, 1'b1);
        rst = 1'b1;
        #1;
        checks++;
        if (s_ready !== 4'b0000 || crc_flitEn !== 1'b0 || crc_din !== 32'h0 || res_vld !== 1'b0 || tag_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: got ready=%b flitEn=%b din=%h res_vld=%b tag_err=%b expected all 0",
                     s_ready, crc_flitEn, crc_din, res_vld, tag_err);
        end
        tick();
        set_src(3, 32'h0, 4'h0, 1'b0, 1'b0);
        rst = 1'b0;
        set_src(0, 32'h0BAD_CAFE, 4'hF, 1'b1, 1'b1);
        tick();
        checks++;
        if (last_acc !== 4'b0001) begin
            errors++;
            $display("FAIL midrst_next_grant: got acc=%b expected 0001", last_acc);
        end
        set_src(0, 32'h0, 4'h0, 1'b0, 1'b0);
        drain(1, ok);
        repeat (3) tick();
        checks++;
        if (!ok || res_src_q.size() != 1 || res_src_q[0] !== 2'd0 || res_crc_q[0] !== exp_crc || tag_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_result: got n=%0d tag_err=%b expected n=1 src=0 crc=%h tag_err=0",
                     res_src_q.size(), tag_err, exp_crc);
        end
        force_vld = 1'b1;
        tick();
        tick();
        checks++;
        if (tag_err !== 1'b1) begin
            errors++;
            $display("FAIL tag_err_set: got %b expected 1", tag_err);
        end
        repeat (3) tick();
        checks++;
        if (tag_err !== 1'b1) begin
            errors++;
            $display("FAIL tag_err_sticky: got %b expected 1", tag_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_src();
        test_round_robin();
        test_lock();
        test_tag_full();
        test_partial();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
